// File: rtl/tff_pkg.sv
// Shared types and defaults for the toggle-signalling receive path.
package tff_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PEND_W      = 3;
    localparam int DEF_CNT_W       = 8;
    localparam int MAX_PEND        = (1 << DEF_PEND_W) - 1;

    function automatic int max_pend(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a level that toggles once per remote event.
module toggle_sync
    import tff_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic tgl_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tff_toggle_receiver.sv
// Recovers one event per remote toggle, buffers it in a saturating pending
// counter and hands events to a consumer over valid/ready.
module tff_toggle_receiver
    import tff_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PEND_W      = DEF_PEND_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgl_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  total_cnt,
    output logic              ovf,
    input  logic              clr_ovf
);

    localparam int                INIT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(max_pend(PEND_W));

    state_e              state_q;
    logic [INIT_W-1:0]   init_q;
    logic                prev_q;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic                ovf_q, ovf_d;
    logic                sync_out;
    logic                evt, pop, full;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .tgl_in  (tgl_in),
        .sync_out(sync_out)
    );

    // While INIT, prev tracks the synchronised level so the post-reset level
    // becomes the baseline instead of a spurious event.
    always_comb begin
        evt     = (state_q == RUN) && (sync_out != prev_q);
        pop     = evt_valid && evt_ready;
        full    = (pend_q == PEND_FULL);
        pend_d  = pend_q;
        ovf_d   = clr_ovf ? 1'b0 : ovf_q;
        total_d = evt ? total_q + CNT_W'(1) : total_q;
        if (evt && !pop) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (pop && !evt) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            init_q  <= INIT_W'(SYNC_STAGES);
            prev_q  <= 1'b0;
            pend_q  <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= sync_out;
            pend_q  <= pend_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
            case (state_q)
                INIT: begin
                    if (init_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        init_q <= init_q - INIT_W'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign evt_valid = (pend_q != '0);
    assign pend_cnt  = pend_q;
    assign total_cnt = total_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_tff_toggle_receiver.sv
// Scoreboard bench for tff_toggle_receiver with a behavioural event model.
module tb_tff_toggle_receiver;

    localparam int SYNC = 2;
    localparam int PW   = 3;
    localparam int CW   = 8;
    localparam int FULL = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          tgl_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [PW-1:0] pend_cnt;
    logic [CW-1:0] total_cnt;
    logic          ovf;
    logic          clr_ovf;

    typedef struct {
        int pend;
        int total;
    } exp_t;

    exp_t sb[$];
    int   det[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    int   rel_edge = 0;
    int   m_pend  = 0;
    int   m_total = 0;
    int   m_ovf   = 0;
    logic tgl_last = 1'b0;

    always #5 clk = ~clk;

    tff_toggle_receiver #(
        .SYNC_STAGES(SYNC),
        .PEND_W     (PW),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tgl_in   (tgl_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .pend_cnt (pend_cnt),
        .total_cnt(total_cnt),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs for the next edge, then advance the model.
    // A level change sampled at edge k counts at edge k+SYNC; changes sampled
    // on the first edge after reset release are absorbed as the new baseline.
    task automatic cyc(input logic t, input logic r, input logic c);
        logic pop;
        logic evt;
        tgl_in    = t;
        evt_ready = r;
        clr_ovf   = c;
        if (t != tgl_last) begin
            if (edge_n + 1 - rel_edge >= 2) det.push_back(edge_n + 1 + SYNC);
            tgl_last = t;
        end
        pop = (m_pend > 0) && r;
        if (pop) sb.push_back('{m_pend, m_total % 256});
        @(posedge clk);
        edge_n++;
        #1;
        evt = (det.size() > 0) && (det[0] == edge_n);
        if (evt) void'(det.pop_front());
        if (evt) m_total++;
        if (c) m_ovf = 0;
        if (evt && !pop) begin
            if (m_pend == FULL) m_ovf = 1;
            else m_pend++;
        end else if (pop && !evt) begin
            m_pend--;
        end
    endtask

    task automatic tog(input logic r, input int n_idle);
        cyc(~tgl_in, r, 1'b0);
        for (int i = 0; i < n_idle; i++) cyc(tgl_in, r, 1'b0);
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++) cyc(tgl_in, r, 1'b0);
    endtask

    task automatic model_clear();
        check("sb_drained", sb.size(), 0);
        m_pend = 0; m_total = 0; m_ovf = 0;
        det.delete();
        sb.delete();
    endtask

    task automatic do_reset(input logic lvl);
        tgl_in = lvl; tgl_last = lvl; evt_ready = 1'b0; clr_ovf = 1'b0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        edge_n += 2;
        #1;
        rst = 1'b0;
        rel_edge = edge_n;
    endtask

    // Monitor: compares visible state each cycle and pops the scoreboard on
    // every accepted handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("valid", int'(evt_valid), int'(m_pend != 0));
                check("pend", int'(pend_cnt), m_pend);
                check("total", int'(total_cnt), m_total % 256);
                check("ovf", int'(ovf), m_ovf);
                if (evt_valid && evt_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL hs_unexpected: got handshake, expected none (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("hs_pend", int'(pend_cnt), e.pend);
                        check("hs_total", int'(total_cnt), e.total);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int gap;
        rst = 1'b1; tgl_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_pend", int'(pend_cnt), 0);
        check("rst_total", int'(total_cnt), 0);
        check("rst_ovf", int'(ovf), 0);

        // 1: level held high through reset gives no event
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            check("t1_valid", int'(evt_valid), 0);
        end
        check("t1_total", int'(total_cnt), 0);
        check("t1_pend", int'(pend_cnt), 0);

        // 2: single toggle, one-cycle valid at k+2
        cyc(1'b0, 1'b1, 1'b0);
        check("t2_k0", int'(evt_valid), 0);
        cyc(1'b0, 1'b1, 1'b0);
        check("t2_k1", int'(evt_valid), 0);
        cyc(1'b0, 1'b1, 1'b0);
        check("t2_k2", int'(evt_valid), 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("t2_k3", int'(evt_valid), 0);
        check("t2_total", int'(total_cnt), 1);
        check("t2_pend", int'(pend_cnt), 0);

        // 3: saturation, overflow and drain
        do_reset(1'b0);
        idle(1'b0, 3);
        for (int i = 0; i < 9; i++) begin
            tog(1'b0, 3);
            if (i == 6) check("t3_ovf7", int'(ovf), 0);
            if (i == 7) check("t3_ovf8", int'(ovf), 1);
        end
        check("t3_pend", int'(pend_cnt), 7);
        check("t3_total", int'(total_cnt), 9);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (evt_valid) acc++;
            cyc(tgl_in, 1'b1, 1'b0);
        end
        check("t3_accepted", acc, 7);
        check("t3_valid", int'(evt_valid), 0);
        check("t3_ovf_sticky", int'(ovf), 1);
        cyc(tgl_in, 1'b0, 1'b1);
        check("t3_ovf_clr", int'(ovf), 0);

        // 4: pop and event together when full; clear loses to a drop
        do_reset(1'b0);
        idle(1'b0, 3);
        for (int i = 0; i < 7; i++) tog(1'b0, 1);
        idle(1'b0, 3);
        check("t4_full", int'(pend_cnt), 7);
        cyc(~tgl_in, 1'b0, 1'b0);
        cyc(tgl_in, 1'b0, 1'b0);
        cyc(tgl_in, 1'b1, 1'b0);
        check("t4_pend_hold", int'(pend_cnt), 7);
        check("t4_no_ovf", int'(ovf), 0);
        check("t4_total", int'(total_cnt), 8);
        cyc(tgl_in, 1'b0, 1'b0);
        cyc(~tgl_in, 1'b0, 1'b0);
        cyc(tgl_in, 1'b0, 1'b0);
        cyc(tgl_in, 1'b0, 1'b1);
        check("t4_set_wins", int'(ovf), 1);
        cyc(tgl_in, 1'b0, 1'b1);
        check("t4_clr", int'(ovf), 0);

        // 5: total_cnt wraps
        do_reset(1'b0);
        idle(1'b0, 3);
        for (int i = 0; i < 256; i++) tog(1'b1, 1);
        idle(1'b1, 4);
        check("t5_wrap", int'(total_cnt), 0);
        tog(1'b1, 4);
        check("t5_after", int'(total_cnt), 1);

        // 6: asynchronous reset mid-operation, then new baseline
        do_reset(1'b0);
        idle(1'b0, 3);
        for (int i = 0; i < 7; i++) tog(1'b1, 1);
        idle(1'b1, 4);
        for (int i = 0; i < 5; i++) tog(1'b0, 1);
        idle(1'b0, 4);
        check("t6_pend", int'(pend_cnt), 5);
        check("t6_total", int'(total_cnt), 12);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("t6_rst_valid", int'(evt_valid), 0);
        check("t6_rst_pend", int'(pend_cnt), 0);
        check("t6_rst_total", int'(total_cnt), 0);
        check("t6_rst_ovf", int'(ovf), 0);
        @(posedge clk);
        edge_n++;
        #1;
        rst = 1'b0;
        rel_edge = edge_n;
        cyc(tgl_in, 1'b0, 1'b0);
        cyc(~tgl_in, 1'b0, 1'b0);
        idle(1'b0, 4);
        check("t6_first", int'(total_cnt), 1);
        check("t6_first_pend", int'(pend_cnt), 1);

        // Randomised traffic at the legal toggle rate
        do_reset(1'($urandom_range(0, 1)));
        idle(1'b0, 3);
        gap = 0;
        for (int i = 0; i < 500; i++) begin
            logic t;
            t = tgl_in;
            gap++;
            if (gap >= 2 && ($urandom % 3) == 0) begin
                t = ~tgl_in;
                gap = 0;
            end
            cyc(t, 1'($urandom_range(0, 1)), 1'(($urandom % 16) == 0));
        end
        idle(1'b1, 12);
        check("rand_drain", int'(pend_cnt), 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
